// File: rtl/posit_div_issue_if.sv
// Operand/result stream bundle for the posit divider issue controller.
// The slave side is the controller; the master side is the producer/consumer.
interface posit_div_issue_if #(
    parameter int N = 32
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_in1;
    logic [N-1:0] s_in2;
    logic         m_valid;
    logic         m_ready;
    logic [N-1:0] m_out;
    logic         m_inf;
    logic         m_zero;

    modport slave (
        input  s_valid, s_in1, s_in2, m_ready,
        output s_ready, m_valid, m_out, m_inf, m_zero
    );

    modport master (
        output s_valid, s_in1, s_in2, m_ready,
        input  s_ready, m_valid, m_out, m_inf, m_zero
    );
endinterface

// File: rtl/posit_div_issue.sv
// Issue/collect controller around a fixed-latency, non-stallable posit divider.
// Issued pairs are tagged through a latency-matched shift register; results land in a credit-protected FIFO.
module posit_div_issue #(
    parameter int N     = 32,
    parameter int LAT   = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    posit_div_issue_if.slave sif,
    output logic             dv_start,
    output logic [N-1:0]     dv_in1,
    output logic [N-1:0]     dv_in2,
    input  logic [N-1:0]     dv_out,
    input  logic             dv_inf,
    input  logic             dv_zero,
    output logic             busy
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic           iss_vld;
    logic [LAT-1:0] tag_sr;
    logic [CW-1:0]  infl;
    logic [CW-1:0]  fcnt;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [N+1:0]   mem [DEPTH];
    logic [N+1:0]   head;
    logic [CW:0]    used;
    logic           fire;
    logic           wr;
    logic           pop;

    assign fire = sif.s_valid && sif.s_ready;
    assign wr   = tag_sr[LAT-1];
    assign pop  = sif.m_valid && sif.m_ready;

    // Credit covers both in-flight pairs and parked results, so the divider never overruns the FIFO.
    assign used        = {1'b0, infl} + {1'b0, fcnt};
    assign sif.s_ready = !rst && (used < DEPTH_C);

    // Issue stage: operands registered toward the divider
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_start <= 1'b0;
            iss_vld  <= 1'b0;
            dv_in1   <= '0;
            dv_in2   <= '0;
        end else begin
            dv_start <= 1'b1;
            iss_vld  <= fire;
            if (fire) begin
                dv_in1 <= sif.s_in1;
                dv_in2 <= sif.s_in2;
            end
        end
    end

    // Tag pipe: mirrors the divider latency
    generate
        if (LAT > 1) begin : g_tag_multi
            always_ff @(posedge clk) begin
                if (rst) tag_sr <= '0;
                else     tag_sr <= {tag_sr[LAT-2:0], iss_vld};
            end
        end else begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) tag_sr <= '0;
                else     tag_sr <= iss_vld;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) infl <= '0;
        else     infl <= infl + CW'(fire) - CW'(wr);
    end

    // Collect stage: result FIFO
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= {dv_out, dv_inf, dv_zero};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fcnt <= fcnt + CW'(wr) - CW'(pop);
        end
    end

    // Head is forced to zero when empty so outputs never expose stale entries.
    assign head        = mem[rd_ptr];
    assign sif.m_valid = (fcnt != '0);
    assign sif.m_out   = sif.m_valid ? head[N+1:2] : '0;
    assign sif.m_inf   = sif.m_valid && head[1];
    assign sif.m_zero  = sif.m_valid && head[0];

    assign busy = iss_vld | (|tag_sr) | (fcnt != '0);
endmodule

// File: tb/tb_posit_div_issue.sv
// Directed bench for posit_div_issue with a behavioural 12-cycle divider stub.
// Expected quotients are hand-derived posit(32,6) power-of-two encodings.
module tb_posit_div_issue;
    localparam int N     = 32;
    localparam int LAT   = 12;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] eout;
        logic        einf;
        logic        ezero;
    } vec_t;

    logic          clk;
    logic          rst;
    logic          dv_start;
    logic [N-1:0]  dv_in1;
    logic [N-1:0]  dv_in2;
    logic [N-1:0]  dv_out;
    logic          dv_inf;
    logic          dv_zero;
    logic          busy;
    logic [33:0]   dpipe [LAT];

    posit_div_issue_if #(.N(N)) sif ();

    posit_div_issue #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .sif      (sif.slave),
        .dv_start (dv_start),
        .dv_in1   (dv_in1),
        .dv_in2   (dv_in2),
        .dv_out   (dv_out),
        .dv_inf   (dv_inf),
        .dv_zero  (dv_zero),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stub: exact for positive powers of two with regime k in {0,-1}, deterministic garbage otherwise.
    function automatic logic [33:0] div_model(input logic [31:0] a, input logic [31:0] b);
        logic oka, okb;
        int   ea, eb, e;
        logic [31:0] q;
        if (b == 32'h0) return {32'h80000000, 1'b1, 1'b0};
        if (a == 32'h0) return {32'h0, 1'b0, 1'b1};
        oka = !a[31] && (a[22:0] == 23'h0) && (a[30:29] == 2'b10 || a[30:29] == 2'b01);
        okb = !b[31] && (b[22:0] == 23'h0) && (b[30:29] == 2'b10 || b[30:29] == 2'b01);
        ea  = (a[30:29] == 2'b10) ? int'(a[28:23]) : int'(a[28:23]) - 64;
        eb  = (b[30:29] == 2'b10) ? int'(b[28:23]) : int'(b[28:23]) - 64;
        e   = ea - eb;
        if (oka && okb && e >= 0 && e <= 63)
            q = 32'h40000000 | (32'(e) << 23);
        else if (oka && okb && e >= -64 && e < 0)
            q = 32'h20000000 | (32'(e + 64) << 23);
        else
            q = a ^ b;
        return {q, 1'b0, 1'b0};
    endfunction

    always @(posedge clk) begin
        dpipe[0] <= div_model(dv_in1, dv_in2);
        for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign {dv_out, dv_inf, dv_zero} = dpipe[LAT-1];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fires, pops, stalls, stray;
    int   last_fire_cyc, mv_rise_cyc, sr_rise_cyc, first_pop_cyc, last_pop_cyc;
    logic mv_prev = 1'b0;
    logic sr_prev = 1'b0;
    logic busy_at_pop;
    vec_t stim_q[$];
    vec_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then present the next stimulus just after the rising edge.
    task automatic step();
        vec_t v;
        @(negedge clk);
        if (sif.s_valid && sif.s_ready) begin
            v = stim_q.pop_front();
            exp_q.push_back(v);
            fires++;
            last_fire_cyc = cyc;
        end
        if (sif.s_valid && !sif.s_ready) stalls++;
        if (sif.m_valid && !mv_prev) mv_rise_cyc = cyc;
        mv_prev = sif.m_valid;
        if (sif.s_ready && !sr_prev) sr_rise_cyc = cyc;
        sr_prev = sif.s_ready;
        if (sif.m_valid && sif.m_ready) begin
            if (exp_q.size() == 0) begin
                stray++;
            end else begin
                v = exp_q.pop_front();
                chk("q_out", sif.m_out, v.eout);
                chk("q_inf", 32'(sif.m_inf), 32'(v.einf));
                chk("q_zero", 32'(sif.m_zero), 32'(v.ezero));
            end
            pops++;
            if (pops == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            busy_at_pop  = busy;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (stim_q.size() > 0) begin
            sif.s_valid = 1'b1;
            sif.s_in1   = stim_q[0].in1;
            sif.s_in2   = stim_q[0].in2;
        end else begin
            sif.s_valid = 1'b0;
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || exp_q.size() > 0) && n < limit) begin
            step();
            n++;
        end
        chk("drain_left", 32'(stim_q.size() + exp_q.size()), 32'd0);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                        input logic qi, input logic qz);
        vec_t v;
        v.in1 = a; v.in2 = b; v.eout = q; v.einf = qi; v.ezero = qz;
        stim_q.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, n;
        rst         = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_in1   = '0;
        sif.s_in2   = '0;
        sif.m_ready = 1'b0;
        fires = 0; pops = 0; stalls = 0; stray = 0;
        last_fire_cyc = -1; mv_rise_cyc = -1; sr_rise_cyc = -1;
        first_pop_cyc = -1; last_pop_cyc = -1; busy_at_pop = 1'b0;

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_sready", 32'(sif.s_ready), 32'd0);
            chk("rst_mvalid", 32'(sif.m_valid), 32'd0);
            chk("rst_dvstart", 32'(dv_start), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_mout", sif.m_out, 32'd0);
            chk("rst_dvin1", dv_in1, 32'd0);
        end
        rst = 1'b0;
        step();
        chk("rel_dvstart", 32'(dv_start), 32'd1);
        chk("rel_sready", 32'(sif.s_ready), 32'd1);

        // Single divide 4.0 / 2.0
        sif.m_ready = 1'b1;
        mv_rise_cyc = -1;
        push(32'h41000000, 32'h40800000, 32'h40800000, 1'b0, 1'b0);
        drain(40);
        chk("single_lat", 32'(mv_rise_cyc - last_fire_cyc), 32'd14);
        chk("single_busy_after", 32'(busy), 32'd0);

        // Stream of 30 back-to-back pairs: 2^i / 2.0
        pops = 0; stalls = 0;
        for (int i = 0; i < 30; i++)
            push(32'h40000000 | (32'(i) << 23), 32'h40800000,
                 (i == 0) ? 32'h3F800000 : (32'h40000000 | (32'(i - 1) << 23)), 1'b0, 1'b0);
        drain(100);
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_pops", 32'(pops), 32'd30);
        chk("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd29);
        chk("stream_busy_last_pop", 32'(busy_at_pop), 32'd1);
        chk("stream_busy_after", 32'(busy), 32'd0);

        // Backpressure: 2^(i+3) / 2^3
        sif.m_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 20; i++)
            push(32'h40000000 | (32'(i + 3) << 23), 32'h41800000,
                 32'h40000000 | (32'(i) << 23), 1'b0, 1'b0);
        repeat (40) step();
        chk("bp_accepts", 32'(fires), 32'd16);
        chk("bp_sready_low", 32'(sif.s_ready), 32'd0);
        chk("bp_no_pop_mvalid", 32'(sif.m_valid), 32'd1);
        pops = 0; sr_rise_cyc = -1;
        sif.m_ready = 1'b1;
        drain(80);
        chk("bp_sready_ret", 32'(sr_rise_cyc - first_pop_cyc), 32'd1);
        chk("bp_pops", 32'(pops), 32'd20);

        // Special operands
        push(32'h40000000, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
        push(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b1);
        push(32'h40000000, 32'h40000000, 32'h40000000, 1'b0, 1'b0);
        drain(40);

        // Reset mid-stream with 5 in flight and 3 parked
        sif.m_ready = 1'b0;
        fires = 0;
        for (int i = 0; i < 8; i++)
            push(32'h40000000 | (32'(i) << 23), 32'h40000000,
                 32'h40000000 | (32'(i) << 23), 1'b0, 1'b0);
        n = 0;
        while (fires == 0 && n < 20) begin step(); n++; end
        f0 = last_fire_cyc;
        n = 0;
        while (cyc < f0 + 16 && n < 40) begin step(); n++; end
        chk("mid_fires", 32'(fires), 32'd8);
        chk("mid_pre_mvalid", 32'(sif.m_valid), 32'd1);
        chk("mid_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("mid_mvalid", 32'(sif.m_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        sif.m_ready = 1'b1;
        stray = 0;
        repeat (20) step();
        chk("mid_stray", 32'(stray), 32'd0);
        mv_rise_cyc = -1;
        push(32'h41000000, 32'h40800000, 32'h40800000, 1'b0, 1'b0);
        drain(40);
        chk("mid_fresh_lat", 32'(mv_rise_cyc - last_fire_cyc), 32'd14);
        chk("mid_stray_end", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
